fir_seq_ctrl: RTL
=================

// Module: fir_seq_ctrl
// PURPOSE
//  Sequencer for the single-MAC FIR engine. Takes ap_start/data_length from the AXI-Lite register file
//  and clears the data RAM. For each sample it accepts one AXI-Stream input, drives Tape_Num MAC cycles
//  over tap RAM and data RAM (ring buffer), then hands the result to the AXI-Stream output.
//  Sits between the regfile, the stream ports and the tap/data RAM + MAC datapath.
// PARAMETERS
//  Tape_Num     11  number of taps = data RAM depth
//  pADDR_W       4  RAM word-address width, >= clog2(Tape_Num)
//  pDATA_WIDTH  32  width of data_length and of the sample counter
// PORTS
//  axis_clk     in   1        sole clock, rising edge
//  axis_rst     in   1        asynchronous, active-high reset
//  ap_start     in   1        1-cycle start pulse from regfile; ignored unless ap_idle=1
//  data_length  in   pDATA_W  samples to process, sampled when ap_start is accepted
//  ap_done_clr  in   1        clears ap_done (regfile read of status)
//  ap_idle      out  1        engine idle
//  ap_done      out  1        sticky: last output transferred
//  tlast_err    out  1        sticky: ss_tlast disagreed with expected position; cleared on start
//  ss_tvalid    in   1        input stream valid
//  ss_tlast     in   1        input stream last
//  ss_tready    out  1        input stream ready
//  sm_tready    in   1        output stream ready
//  sm_tvalid    out  1        output stream valid (sm_tdata comes from the MAC accumulator)
//  sm_tlast     out  1        output stream last
//  data_we      out  1        data RAM write enable
//  data_zero    out  1        select zero as data RAM write data (clear phase)
//  data_addr    out  pADDR_W  data RAM address
//  tap_addr     out  pADDR_W  tap RAM address
//  mac_clr      out  1        load accumulator with product instead of accumulating
//  mac_en       out  1        accumulator enable (aligned to 1-cycle RAM read latency)
// BEHAVIOUR
//  Reset: state IDLE; ap_idle=1; every other output 0; head=0; k=0; cnt=0; pipeline regs 0.
//  Reset asserted mid-operation aborts at once; no output is produced; RAM contents are don't-care.
//  IDLE: ap_idle=1. ap_start -> latch len=data_length, cnt=0, head=0, clear ap_done and tlast_err -> CLEAR.
//  CLEAR: Tape_Num cycles, data_we=1, data_zero=1, data_addr=k (0..N-1). Then len==0 ? set ap_done, IDLE
//    : WAIT_IN.
//  WAIT_IN: ss_tready=1; data_addr=head; data_we=ss_tvalid. On accept: tlast_err|=(ss_tlast!=(cnt==len-1));
//    -> MAC with k=0.
//  MAC: N cycles, k=0..N-1: tap_addr=k, data_addr=(head-k) mod N (wraps N-1 after 0).
//    mac_en/mac_clr are the read-issue strobes delayed 1 cycle: mac_en=1 for N cycles, mac_clr with first.
//  FLUSH: 1 cycle (last delayed mac_en) -> OUT.
//  OUT: sm_tvalid=1, sm_tlast=(cnt==len-1), held stable until sm_tready. On transfer: cnt++,
//    head=(head==N-1)?0:head+1; last ? set ap_done, IDLE : WAIT_IN.
//  Latency: input accepted at edge t -> sm_tvalid high from cycle t+N+2 (MAC t+1..t+N, FLUSH t+N+1).
//  Throughput: one sample per N+3 cycles with sm_tready held high. ss_tready=0 outside WAIT_IN.
//  ap_done stays high until ap_done_clr or the next accepted ap_start. If ap_done_clr and ap_done set
//    in the same cycle, set wins.
//  ap_start while busy is dropped. data_length changes after start have no effect.
//  cnt compare is full pDATA_WIDTH unsigned; len=1 gives sm_tlast on the first output.
// STRUCTURE
//  Shared package fir_pkg: state encoding (IDLE,CLEAR,WAIT_IN,MAC,FLUSH,OUT), pADDR_W, Tape_Num default.
//  One sub-module fir_ring_addr: head pointer, modular head-k generator, wrap increment.
//  FSM, counters and strobes in fir_seq_ctrl. All outputs registered or decoded from the state register only.
// TESTING
//  1 reset: axis_rst pulse mid-MAC -> ap_idle=1, sm_tvalid=0, ss_tready=0, data_we=0 next cycle.
//  2 start N=11, len=3: CLEAR shows data_addr 0..10 with data_zero=1; outputs transfer 3 times;
//    sm_tlast on 3rd only; ap_done=1 after it.
//  3 ring wrap, len=13: for sample 12, head=1 and MAC data_addr sequence is 1,0,10,9,..,2;
//    reference model yields y matching.
//  4 backpressure: sm_tready low for 20 cycles in OUT -> sm_tvalid and sm_tlast stable, ss_tready=0,
//    no mac_en.
//  5 len=0 -> no ss_tready, ap_done=1 exactly N+1 cycles after start.
//    ap_start during MAC is ignored (cnt unchanged).
//  6 ss_tlast on sample 2 of len=4 -> tlast_err=1, all 4 outputs still produced.
//    ap_done_clr and done same cycle -> ap_done=1.

Source files
------------

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fir_pkg
//  Brief    : Shared definitions for the single-MAC FIR sequencer: sequencer
//             state encoding and default geometry of the tap/data RAMs.
//  Revision : 1.0  initial release
// ============================================================================
package fir_pkg;

  // Default number of taps; also the data RAM (ring buffer) depth.
  localparam int TAPE_NUM_DEF = 11;
  // Default RAM word-address width; must satisfy 2**ADDR_W_DEF >= TAPE_NUM_DEF.
  localparam int ADDR_W_DEF   = 4;
  // Default width of data_length and the sample counter.
  localparam int DATA_W_DEF   = 32;

  localparam int STATE_W = 3;

  // Sequencer states, explicitly encoded.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_WAIT_IN = 3'd2,
    ST_MAC     = 3'd3,
    ST_FLUSH   = 3'd4,
    ST_OUT     = 3'd5
  } fir_state_e;

endpackage
`default_nettype wire

// File: rtl/fir_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fir_seq_ctrl_if
//  Brief    : Stream handshakes and tap/data RAM + MAC control strobes seen
//             by the FIR sequencer. master = sequencer, slave = ports/datapath.
//  Revision : 1.0  initial release
// ============================================================================
interface fir_seq_ctrl_if #(
  parameter int pADDR_W = fir_pkg::ADDR_W_DEF
);
  import fir_pkg::*;

  // AXI-Stream input handshake (data path is outside the sequencer)
  logic               ss_tvalid;
  logic               ss_tlast;
  logic               ss_tready;
  // AXI-Stream output handshake (sm_tdata comes from the MAC accumulator)
  logic               sm_tready;
  logic               sm_tvalid;
  logic               sm_tlast;
  // Data RAM control
  logic               data_we;
  logic               data_zero;
  logic [pADDR_W-1:0] data_addr;
  // Tap RAM control
  logic [pADDR_W-1:0] tap_addr;
  // MAC control, aligned to the 1-cycle RAM read latency
  logic               mac_clr;
  logic               mac_en;

  modport master (
    input  ss_tvalid, ss_tlast, sm_tready,
    output ss_tready, sm_tvalid, sm_tlast,
    output data_we, data_zero, data_addr, tap_addr,
    output mac_clr, mac_en
  );

  modport slave (
    output ss_tvalid, ss_tlast, sm_tready,
    input  ss_tready, sm_tvalid, sm_tlast,
    input  data_we, data_zero, data_addr, tap_addr,
    input  mac_clr, mac_en
  );

endinterface
`default_nettype wire

// File: rtl/fir_ring_addr.sv
`default_nettype none
// ============================================================================
//  Module   : fir_ring_addr
//  Brief    : Ring-buffer head pointer for the FIR data RAM. Holds the slot
//             of the newest sample and produces (head - k) mod Tape_Num, the
//             slot of the sample that meets tap k.
//  Revision : 1.0  initial release
// ============================================================================
module fir_ring_addr
  import fir_pkg::*;
#(
  parameter int Tape_Num = TAPE_NUM_DEF,
  parameter int pADDR_W  = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               head_clr,
  input  logic               head_inc,
  input  logic [pADDR_W-1:0] k,
  output logic [pADDR_W-1:0] head,
  output logic [pADDR_W-1:0] rd_addr
);

  localparam logic [pADDR_W-1:0] HEAD_LAST = pADDR_W'(Tape_Num - 1);
  // Depth reduced to the address width; when Tape_Num == 2**pADDR_W this is
  // zero and the modulo-2**pADDR_W wrap of the subtraction does the job.
  localparam logic [pADDR_W-1:0] DEPTH_W   = pADDR_W'(Tape_Num);

  // Head pointer: reset on start, advance with wrap after every output transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
    end else if (head_clr) begin
      head <= '0;
    end else if (head_inc) begin
      head <= (head == HEAD_LAST) ? '0 : head + 1'b1;
    end
  end

  // (head - k) mod depth. When k exceeds head the result is head + depth - k,
  // which is always below depth, so address-width arithmetic never overflows
  // into a wrong slot.
  always_comb begin
    if (head >= k) begin
      rd_addr = head - k;
    end else begin
      rd_addr = head + DEPTH_W - k;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fir_seq_ctrl
//  Brief    : Sequencer for the single-MAC FIR engine. Clears the data RAM on
//             start, then for every sample accepts one stream input, walks
//             Tape_Num MAC cycles over tap RAM and the data ring buffer, and
//             presents the accumulator on the output stream.
//  Revision : 1.0  initial release
// ============================================================================
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int Tape_Num    = TAPE_NUM_DEF,
  parameter int pADDR_W     = ADDR_W_DEF,
  parameter int pDATA_WIDTH = DATA_W_DEF
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  // Register-file side
  input  logic                   ap_start,
  input  logic [pDATA_WIDTH-1:0] data_length,
  input  logic                   ap_done_clr,
  output logic                   ap_idle,
  output logic                   ap_done,
  output logic                   tlast_err,
  // Stream handshakes and RAM/MAC strobes; interface must use the same pADDR_W
  fir_seq_ctrl_if.master         bus
);

  localparam logic [pADDR_W-1:0]     K_LAST = pADDR_W'(Tape_Num - 1);
  localparam logic [pDATA_WIDTH-1:0] ONE_D  = pDATA_WIDTH'(1);

  fir_state_e               state;
  fir_state_e               state_nxt;
  logic [pADDR_W-1:0]       k;
  logic [pDATA_WIDTH-1:0]   len;
  logic [pDATA_WIDTH-1:0]   cnt;
  logic                     done_q;
  logic                     tlast_err_q;
  logic                     mac_en_q;
  logic                     mac_clr_q;
  logic [pADDR_W-1:0]       head;
  logic [pADDR_W-1:0]       rd_addr;

  logic                     k_last;
  logic                     cnt_last;
  logic                     start_ok;
  logic                     in_accept;
  logic                     out_xfer;
  logic                     len_zero;

  // Event decodes shared by the state, counter and status logic.
  always_comb begin
    k_last    = (k == K_LAST);
    // Full-width unsigned compare; len=0 never reaches the OUT state.
    cnt_last  = (cnt == (len - ONE_D));
    len_zero  = (len == '0);
    start_ok  = (state == ST_IDLE) && ap_start;
    in_accept = (state == ST_WAIT_IN) && bus.ss_tvalid;
    out_xfer  = (state == ST_OUT) && bus.sm_tready;
  end

  // State register.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (ap_start) state_nxt = ST_CLEAR;
      ST_CLEAR:   if (k_last) state_nxt = len_zero ? ST_IDLE : ST_WAIT_IN;
      ST_WAIT_IN: if (bus.ss_tvalid) state_nxt = ST_MAC;
      ST_MAC:     if (k_last) state_nxt = ST_FLUSH;
      ST_FLUSH:   state_nxt = ST_OUT;
      ST_OUT:     if (bus.sm_tready) state_nxt = cnt_last ? ST_IDLE : ST_WAIT_IN;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Tap/clear index: counts 0..Tape_Num-1 in CLEAR and MAC, parked at 0 elsewhere
  // so every MAC pass starts from tap 0.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      k <= '0;
    end else if ((state == ST_CLEAR) || (state == ST_MAC)) begin
      k <= k_last ? '0 : k + 1'b1;
    end else begin
      k <= '0;
    end
  end

  // Job length latch and output sample counter.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      len <= '0;
      cnt <= '0;
    end else if (start_ok) begin
      len <= data_length;
      cnt <= '0;
    end else if (out_xfer) begin
      cnt <= cnt + ONE_D;
    end
  end

  // Sticky status: done is set by job completion (set beats ap_done_clr),
  // tlast error accumulates over the job; both clear on an accepted start.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      done_q      <= 1'b0;
      tlast_err_q <= 1'b0;
    end else begin
      if ((state == ST_CLEAR && k_last && len_zero) || (out_xfer && cnt_last)) begin
        done_q <= 1'b1;
      end else if (start_ok || ap_done_clr) begin
        done_q <= 1'b0;
      end

      if (start_ok) begin
        tlast_err_q <= 1'b0;
      end else if (in_accept && (bus.ss_tlast != cnt_last)) begin
        tlast_err_q <= 1'b1;
      end
    end
  end

  // MAC strobes trail the RAM read issue by one cycle to match RAM latency;
  // the last one lands in FLUSH.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      mac_en_q  <= 1'b0;
      mac_clr_q <= 1'b0;
    end else begin
      mac_en_q  <= (state == ST_MAC);
      mac_clr_q <= (state == ST_MAC) && (k == '0);
    end
  end

  fir_ring_addr #(
    .Tape_Num (Tape_Num),
    .pADDR_W  (pADDR_W)
  ) u_ring (
    .clk      (axis_clk),
    .rst      (axis_rst),
    .head_clr (start_ok),
    .head_inc (out_xfer),
    .k        (k),
    .head     (head),
    .rd_addr  (rd_addr)
  );

  // Output decode from the state register and the counters.
  always_comb begin
    ap_idle        = (state == ST_IDLE);
    ap_done        = done_q;
    tlast_err      = tlast_err_q;
    bus.ss_tready  = 1'b0;
    bus.sm_tvalid  = 1'b0;
    bus.sm_tlast   = 1'b0;
    bus.data_we    = 1'b0;
    bus.data_zero  = 1'b0;
    bus.data_addr  = '0;
    bus.tap_addr   = '0;
    bus.mac_en     = mac_en_q;
    bus.mac_clr    = mac_clr_q;
    case (state)
      ST_CLEAR: begin
        bus.data_we   = 1'b1;
        bus.data_zero = 1'b1;
        bus.data_addr = k;
      end
      ST_WAIT_IN: begin
        // New sample is written into the head slot in the accepting cycle.
        bus.ss_tready = 1'b1;
        bus.data_we   = bus.ss_tvalid;
        bus.data_addr = head;
      end
      ST_MAC: begin
        bus.tap_addr  = k;
        bus.data_addr = rd_addr;
      end
      ST_OUT: begin
        bus.sm_tvalid = 1'b1;
        bus.sm_tlast  = cnt_last;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
